// File: rtl/bus_dma.sv
// bus_dma: single-channel word-copy DMA engine.
// A small register bank on the device port programs source, destination and
// word count. A host port then copies one 32-bit word at a time, with one
// outstanding transaction. An interrupt is raised on completion or bus error.
//
// Host handshake: req/addr/we/wdata are registered. They stay stable from
// assertion until the cycle in which gnt is high, and req drops in the cycle
// after the grant. One response (rvalid, optionally err) is expected per
// granted request. rvalid is ignored unless a response is outstanding.
module bus_dma #(
  parameter int LenWidth = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,
  output logic        dma_irq_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } state_e;

  state_e               r_state;
  logic [31:0]          r_src;
  logic [31:0]          r_dst;
  logic [LenWidth-1:0]  r_len;
  logic                 r_irq_en;
  logic                 r_done;
  logic                 r_err;
  logic [31:0]          r_wsrc;
  logic [31:0]          r_wdst;
  logic [LenWidth-1:0]  r_wlen;

  logic [2:0]           w_sel;
  logic                 w_wr;
  logic                 w_busy;
  logic                 w_start;
  logic                 w_clr_done;
  logic                 w_clr_err;
  logic [LenWidth-1:0]  w_len_next;
  logic [31:0]          w_rdata;
  logic                 w_unused;

  assign w_sel      = device_addr_i[4:2];
  assign w_wr       = device_req_i & device_we_i;
  assign w_busy     = (r_state != ST_IDLE);
  assign w_start    = w_wr & (w_sel == 3'd3) & device_wdata_i[0] & ~w_busy;
  assign w_clr_done = w_wr & (w_sel == 3'd4) & device_wdata_i[1];
  assign w_clr_err  = w_wr & (w_sel == 3'd4) & device_wdata_i[2];
  assign w_len_next = r_wlen - LenWidth'(1);
  assign host_be_o  = 4'hF;
  assign dma_irq_o  = r_irq_en & (r_done | r_err);
  // Byte enables and undecoded address bits have no effect.
  assign w_unused   = ^{device_be_i, device_addr_i[31:5], device_addr_i[1:0]};

  // Register read mux; unmapped offsets read as zero.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      3'd0:    w_rdata = r_src;
      3'd1:    w_rdata = r_dst;
      3'd2:    w_rdata = 32'(r_len);
      3'd3:    w_rdata = {30'd0, r_irq_en, 1'b0};
      3'd4:    w_rdata = {29'd0, r_err, r_done, w_busy};
      default: w_rdata = '0;
    endcase
  end

  // Programmed registers; the transfer setup is frozen while busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_irq_en <= 1'b0;
    end else if (w_wr) begin
      case (w_sel)
        3'd0:    if (!w_busy) r_src <= {device_wdata_i[31:2], 2'b00};
        3'd1:    if (!w_busy) r_dst <= {device_wdata_i[31:2], 2'b00};
        3'd2:    if (!w_busy) r_len <= device_wdata_i[LenWidth-1:0];
        3'd3:    r_irq_en <= device_wdata_i[1];
        default: ;
      endcase
    end
  end

  // Device response: one cycle after each request; writes return zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= (device_req_i && !device_we_i) ? w_rdata : '0;
    end
  end

  // Copy FSM. It owns DONE/ERR, so a set by the FSM overrides a same-cycle W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_wsrc       <= '0;
      r_wdst       <= '0;
      r_wlen       <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      host_req_o   <= 1'b0;
      host_we_o    <= 1'b0;
      host_addr_o  <= '0;
      host_wdata_o <= '0;
    end else begin
      if (w_clr_done) r_done <= 1'b0;
      if (w_clr_err)  r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_wsrc <= r_src;
            r_wdst <= r_dst;
            r_wlen <= r_len;
            if (r_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= ST_RD_REQ;
              host_req_o  <= 1'b1;
              host_we_o   <= 1'b0;
              host_addr_o <= r_src;
            end
          end
        end
        ST_RD_REQ: begin
          if (host_gnt_i) begin
            host_req_o <= 1'b0;
            r_state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (host_rvalid_i) begin
            if (host_err_i) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              host_wdata_o <= host_rdata_i;
              host_req_o   <= 1'b1;
              host_we_o    <= 1'b1;
              host_addr_o  <= r_wdst;
              r_state      <= ST_WR_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (host_gnt_i) begin
            host_req_o <= 1'b0;
            r_state    <= ST_WR_WAIT;
          end
        end
        ST_WR_WAIT: begin
          if (host_rvalid_i) begin
            if (host_err_i) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_wsrc <= r_wsrc + 32'd4;
              r_wdst <= r_wdst + 32'd4;
              r_wlen <= w_len_next;
              if (w_len_next == '0) begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                host_req_o  <= 1'b1;
                host_we_o   <= 1'b0;
                host_addr_o <= r_wsrc + 32'd4;
                r_state     <= ST_RD_REQ;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: directed and randomized copies of bus_dma.
// A memory model answers the host port. Expected bus traffic and memory
// contents come from a word-level copy model.
module tb_bus_dma;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        device_req_i = 1'b0;
  logic [31:0] device_addr_i = '0;
  logic        device_we_i = 1'b0;
  logic [3:0]  device_be_i = 4'hF;
  logic [31:0] device_wdata_i = '0;
  logic        device_rvalid_o;
  logic [31:0] device_rdata_o;
  logic        host_req_o;
  logic        host_gnt_i;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i;
  logic [31:0] host_rdata_i;
  logic        host_err_i;
  logic        dma_irq_o;

  localparam logic [31:0] A_SRC = 32'h00, A_DST = 32'h04, A_LEN = 32'h08;
  localparam logic [31:0] A_CTRL = 32'h0C, A_STAT = 32'h10;

  // clock / reset
  always #5 clk_i = ~clk_i;

  bus_dma #(.LenWidth(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .device_req_i(device_req_i), .device_addr_i(device_addr_i),
    .device_we_i(device_we_i), .device_be_i(device_be_i),
    .device_wdata_i(device_wdata_i), .device_rvalid_o(device_rvalid_o),
    .device_rdata_o(device_rdata_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i),
    .host_err_i(host_err_i), .dma_irq_o(dma_irq_o)
  );

  int n_chk = 0;
  int n_err = 0;

  // scoreboard: transactions packed as {we, addr, wdata (0 for reads)}
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];
  logic [31:0] src_words[$];
  logic [31:0] mem [logic [31:0]];
  int          gnt_delay [int];
  int          err_txn = -1;
  int          txn_idx = 0;
  bit          spur = 1'b0;
  logic [31:0] cur_dst;
  int          cur_len;
  int          committed;
  logic [31:0] exp_status;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // bus memory responder: optional grant stalls, error injection, rvalid one cycle after grant
  initial begin : responder
    bit          resp_pending;
    bit          resp_err;
    logic [31:0] resp_data;
    int          wait_cnt;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic        hold_we;
    int          dly;
    resp_pending = 1'b0;
    resp_err = 1'b0;
    resp_data = '0;
    wait_cnt = 0;
    hold_addr = '0;
    hold_wdata = '0;
    hold_we = 1'b0;
    host_gnt_i = 1'b0;
    host_rvalid_i = 1'b0;
    host_err_i = 1'b0;
    host_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      host_gnt_i = 1'b0;
      host_rvalid_i = 1'b0;
      host_err_i = 1'b0;
      if (!rst_ni) begin
        resp_pending = 1'b0;
        wait_cnt = 0;
      end else begin
        if (resp_pending) begin
          host_rvalid_i = 1'b1;
          host_err_i = resp_err;
          host_rdata_i = resp_data;
          resp_pending = 1'b0;
        end else if (spur) begin
          host_rvalid_i = 1'b1;
          host_err_i = 1'b1;
          host_rdata_i = 32'hBAD0BAD0;
          spur = 1'b0;
        end
        if (host_req_o) begin
          if (wait_cnt == 0) begin
            hold_addr = host_addr_o;
            hold_we = host_we_o;
            hold_wdata = host_wdata_o;
          end else begin
            chk("hold_addr", host_addr_o, hold_addr);
            chk("hold_we", host_we_o, hold_we);
            chk("hold_wdata", host_wdata_o, hold_wdata);
          end
          dly = gnt_delay.exists(txn_idx) ? gnt_delay[txn_idx] : 0;
          if (wait_cnt < dly) begin
            wait_cnt++;
          end else begin
            chk("host_be", host_be_o, 4'hF);
            host_gnt_i = 1'b1;
            wait_cnt = 0;
            resp_err = (txn_idx == err_txn);
            obs_q.push_back({host_we_o, host_addr_o, host_we_o ? host_wdata_o : 32'h0});
            if (host_we_o) begin
              if (!resp_err) mem[host_addr_o] = host_wdata_o;
              resp_data = $urandom;
            end else begin
              resp_data = mem.exists(host_addr_o) ? mem[host_addr_o] : 32'h0;
            end
            resp_pending = 1'b1;
            txn_idx++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic dev_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    @(negedge clk_i);
    device_req_i = 1'b1;
    device_we_i = we;
    device_addr_i = addr;
    device_wdata_i = wdata;
    @(negedge clk_i);
    device_req_i = 1'b0;
    device_we_i = 1'b0;
    chk("dev_rvalid", device_rvalid_o, 1'b1);
    rdata = device_rdata_o;
    if (we) chk("dev_wr_rdata", device_rdata_o, 32'h0);
  endtask

  task automatic dev_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    dev_access(1'b1, addr, wdata, d);
  endtask

  task automatic dev_read(input logic [31:0] addr, output logic [31:0] rdata);
    dev_access(1'b0, addr, 32'h0, rdata);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
    logic [31:0] d;
    dev_read(addr, d);
    chk(tag, d, exp_v);
  endtask

  task automatic program_regs(input logic [31:0] src, input logic [31:0] dst, input int len);
    dev_write(A_SRC, src);
    dev_write(A_DST, dst);
    dev_write(A_LEN, 32'(len));
  endtask

  // reference model: a copy of len words is len read/write pairs at ascending addresses
  task automatic prepare(input logic [31:0] src, input logic [31:0] dst, input int len,
                         input int err_at);
    logic [31:0] w;
    src_words.delete();
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      src_words.push_back(w);
      mem[src + 32'(4 * i)] = w;
      mem[dst + 32'(4 * i)] = 32'hA5A50000 | 32'(i);
    end
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({1'b0, src + 32'(4 * i), 32'h0});
      exp_q.push_back({1'b1, dst + 32'(4 * i), src_words[i]});
    end
    if (err_at >= 0)
      while (exp_q.size() > err_at + 1) void'(exp_q.pop_back());
    cur_dst = dst;
    cur_len = len;
    committed = (err_at >= 0) ? err_at / 2 : len;
    exp_status = (err_at >= 0) ? 32'h4 : 32'h2;
    txn_idx = 0;
    err_txn = err_at;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int k;
    k = 0;
    s = 32'h1;
    while (s[0] && k < 500) begin
      dev_read(A_STAT, s);
      k++;
    end
    chk({tag, "_idle_timeout"}, s[0], 1'b0);
  endtask

  task automatic check_results(input string tag);
    int n;
    logic [31:0] d;
    read_chk({tag, "_status"}, A_STAT, exp_status);
    chk({tag, "_ntxn"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_txn"}, obs_q[i], exp_q[i]);
    for (int i = 0; i < cur_len; i++) begin
      d = cur_dst + 32'(4 * i);
      chk({tag, "_mem"}, mem[d], (i < committed) ? src_words[i] : (32'hA5A50000 | 32'(i)));
    end
  endtask

  initial begin : watchdog
    #900000;
    n_err++;
    $error("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // directed sequence followed by randomized copies
  initial begin : main
    int k;
    logic [31:0] s;
    logic [31:0] rs;
    logic [31:0] rd;
    int rl;
    int re;

    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_host_req", host_req_o, 1'b0);
    chk("rst_host_addr", host_addr_o, 32'h0);
    chk("rst_host_we", host_we_o, 1'b0);
    chk("rst_host_wdata", host_wdata_o, 32'h0);
    chk("rst_dev_rvalid", device_rvalid_o, 1'b0);
    chk("rst_dev_rdata", device_rdata_o, 32'h0);
    chk("rst_irq", dma_irq_o, 1'b0);
    rst_ni = 1'b1;
    read_chk("rst_status", A_STAT, 32'h0);
    read_chk("rst_src", A_SRC, 32'h0);
    read_chk("rst_len", A_LEN, 32'h0);

    // register map basics
    dev_write(A_SRC, 32'h12345677);
    read_chk("src_lowbits", A_SRC, 32'h12345674);
    dev_write(A_LEN, 32'hABCD1234);
    read_chk("len_width", A_LEN, 32'h00001234);
    dev_write(32'h18, 32'hFFFFFFFF);
    read_chk("unmapped", 32'h18, 32'h0);
    dev_write(A_CTRL, 32'h2);
    read_chk("ctrl_rd", A_CTRL, 32'h2);
    dev_write(A_CTRL, 32'h0);

    // 4-word copy on a zero-wait bus, DONE/irq at T+17
    gnt_delay.delete();
    prepare(32'h00100000, 32'h00108000, 4, -1);
    program_regs(32'h00100000, 32'h00108000, 4);
    dev_write(A_CTRL, 32'h3);
    chk("req_at_T1", host_req_o, 1'b1);
    k = 1;
    while (!dma_irq_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    chk("done_cycle", 32'(k), 32'd17);
    check_results("copy4");

    // re-START repeats the copy; a W1C DONE on the completion edge loses
    prepare(32'h00100000, 32'h00108000, 4, -1);
    dev_write(A_CTRL, 32'h3);
    repeat (14) @(negedge clk_i);
    dev_write(A_STAT, 32'h2);
    check_results("restart_w1c");
    dev_write(A_STAT, 32'h2);

    // LEN=0: no bus traffic, DONE and irq next cycle, W1C drops irq
    prepare(32'h00110000, 32'h00118000, 0, -1);
    program_regs(32'h00110000, 32'h00118000, 0);
    dev_write(A_CTRL, 32'h3);
    chk("len0_irq", dma_irq_o, 1'b1);
    chk("len0_noreq", host_req_o, 1'b0);
    check_results("len0");
    dev_write(A_STAT, 32'h2);
    chk("len0_irq_clr", dma_irq_o, 1'b0);

    // stray response while idle is ignored
    spur = 1'b1;
    repeat (3) @(negedge clk_i);
    read_chk("spurious_rvalid", A_STAT, 32'h0);

    // grant withheld 5 cycles on the 2nd read
    prepare(32'h00200000, 32'h00208000, 4, -1);
    gnt_delay[2] = 5;
    program_regs(32'h00200000, 32'h00208000, 4);
    dev_write(A_CTRL, 32'h1);
    wait_idle("stall");
    check_results("stall");
    gnt_delay.delete();

    // bus error on the 3rd write of an 8-word copy
    prepare(32'h00300000, 32'h00308000, 8, 5);
    program_regs(32'h00300000, 32'h00308000, 8);
    dev_write(A_CTRL, 32'h3);
    wait_idle("err");
    repeat (20) @(negedge clk_i);
    check_results("err");
    chk("err_irq", dma_irq_o, 1'b1);
    dev_write(A_STAT, 32'h4);
    read_chk("err_clr", A_STAT, 32'h0);

    // setup writes and START while busy are dropped
    prepare(32'h00400000, 32'h00408000, 6, -1);
    program_regs(32'h00400000, 32'h00408000, 6);
    dev_write(A_CTRL, 32'h1);
    repeat (3) @(negedge clk_i);
    dev_write(A_SRC, 32'hDEADBEEC);
    dev_write(A_CTRL, 32'h1);
    wait_idle("busy_wr");
    read_chk("busy_src", A_SRC, 32'h00400000);
    check_results("busy_wr");

    // source address wraps past 0xFFFFFFFC
    prepare(32'hFFFFFFF8, 32'h00500000, 3, -1);
    program_regs(32'hFFFFFFF8, 32'h00500000, 3);
    dev_write(A_CTRL, 32'h1);
    wait_idle("wrap");
    check_results("wrap");

    // randomized copies with random stalls and occasional errors
    for (int it = 0; it < 8; it++) begin
      rs = 32'h10000000 + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      rd = 32'h40000000 + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      rl = $urandom_range(1, 12);
      re = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * rl - 1) : -1;
      prepare(rs, rd, rl, re);
      gnt_delay.delete();
      for (int t = 0; t < 2 * rl; t++) gnt_delay[t] = $urandom_range(0, 3);
      program_regs(rs, rd, rl);
      dev_write(A_CTRL, 32'h1);
      wait_idle("rand");
      check_results("rand");
    end
    gnt_delay.delete();

    // asynchronous reset mid-transfer drops the request at once
    prepare(32'h00600000, 32'h00608000, 4, -1);
    program_regs(32'h00600000, 32'h00608000, 4);
    dev_write(A_CTRL, 32'h3);
    chk("mid_req_up", host_req_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_req_drop", host_req_o, 1'b0);
    chk("async_addr", host_addr_o, 32'h0);
    chk("async_irq", dma_irq_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    obs_q.delete();
    repeat (4) @(negedge clk_i);
    chk("post_rst_notxn", obs_q.size(), 0);
    read_chk("post_rst_status", A_STAT, 32'h0);
    read_chk("post_rst_src", A_SRC, 32'h0);
    read_chk("post_rst_ctrl", A_CTRL, 32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
